// File: rtl/olivia_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : olivia_pkg
//  Description : Shared types and constants for the Olivia program loader.
//  Revision    : 1.0  initial release
// ============================================================================
package olivia_pkg;

    typedef enum logic [2:0] {
        HDR_HI = 3'd0,
        HDR_LO = 3'd1,
        DATA   = 3'd2,
        CSUM   = 3'd3,
        FILL   = 3'd4,
        DONE   = 3'd5,
        ERR    = 3'd6
    } load_state_t;

    localparam logic [7:0] NOP_BYTE  = 8'h00;
    localparam int         HDR_BYTES = 2;

endpackage
`default_nettype wire

// File: rtl/im_loader.sv
`default_nettype none
// ============================================================================
//  Module      : im_loader
//  Description : Byte-serial framed program loader writing the Olivia IM
//                big-endian; holds the core in reset until verified.
//  Revision    : 1.0  initial release
// ============================================================================
module im_loader
    import olivia_pkg::*;
#(
    parameter int IM_BYTES = 64,
    parameter int ADDR_W   = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [7:0]        im_wdata,
    output logic              core_rst,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W-2:0] word_count
);

    localparam logic [ADDR_W:0] c_ptr_end   = (ADDR_W+1)'(IM_BYTES);
    localparam logic [ADDR_W:0] c_ptr_last  = (ADDR_W+1)'(IM_BYTES - 1);
    localparam logic [15:0]     c_max_words = 16'(IM_BYTES / 4);

    load_state_t       r_state,      w_state_nxt;
    logic [7:0]        r_n_hi,       w_n_hi_nxt;
    logic [ADDR_W-2:0] r_n_words,    w_n_words_nxt;
    logic [ADDR_W:0]   r_ptr,        w_ptr_nxt;
    logic [7:0]        r_csum,       w_csum_nxt;
    logic [ADDR_W-2:0] r_word_count, w_word_count_nxt;
    logic              r_im_we,      w_im_we_nxt;
    logic [ADDR_W-1:0] r_im_addr,    w_im_addr_nxt;
    logic [7:0]        r_im_wdata,   w_im_wdata_nxt;
    logic              r_load_done,  w_load_done_nxt;
    logic              r_load_err,   w_load_err_nxt;

    logic              w_xfer;
    logic [15:0]       w_n;
    logic [ADDR_W:0]   w_ptr_inc;

    assign in_ready  = (r_state == HDR_HI) || (r_state == HDR_LO) ||
                       (r_state == DATA)   || (r_state == CSUM);
    assign w_xfer    = in_valid && in_ready;
    assign w_n       = {r_n_hi, in_data};
    assign w_ptr_inc = r_ptr + 1'b1;

    always_comb begin
        w_state_nxt      = r_state;
        w_n_hi_nxt       = r_n_hi;
        w_n_words_nxt    = r_n_words;
        w_ptr_nxt        = r_ptr;
        w_csum_nxt       = r_csum;
        w_word_count_nxt = r_word_count;
        w_im_we_nxt      = 1'b0;
        w_im_addr_nxt    = r_im_addr;
        w_im_wdata_nxt   = r_im_wdata;
        w_load_done_nxt  = r_load_done;
        w_load_err_nxt   = r_load_err;

        case (r_state)
            HDR_HI: begin
                if (w_xfer) begin
                    w_n_hi_nxt  = in_data;
                    w_state_nxt = HDR_LO;
                end
            end
            HDR_LO: begin
                if (w_xfer) begin
                    if (w_n > c_max_words) begin
                        w_state_nxt    = ERR;
                        w_load_err_nxt = 1'b1;
                    end else begin
                        // Safe truncation: w_n is bounded by IM_BYTES/4 here
                        w_n_words_nxt = w_n[ADDR_W-2:0];
                        w_state_nxt   = (w_n == 16'd0) ? CSUM : DATA;
                    end
                end
            end
            DATA: begin
                if (w_xfer) begin
                    w_im_we_nxt    = 1'b1;
                    w_im_addr_nxt  = r_ptr[ADDR_W-1:0];
                    w_im_wdata_nxt = in_data;
                    w_csum_nxt     = r_csum ^ in_data;
                    w_ptr_nxt      = w_ptr_inc;
                    if (r_ptr[1:0] == 2'b11)
                        w_word_count_nxt = r_word_count + 1'b1;
                    if (w_ptr_inc == {r_n_words, 2'b00})
                        w_state_nxt = CSUM;
                end
            end
            CSUM: begin
                if (w_xfer) begin
                    if (in_data != r_csum) begin
                        w_state_nxt    = ERR;
                        w_load_err_nxt = 1'b1;
                    end else if (r_ptr == c_ptr_end) begin
                        w_state_nxt     = DONE;
                        w_load_done_nxt = 1'b1;
                    end else begin
                        w_state_nxt = FILL;
                    end
                end
            end
            FILL: begin
                // Pad the unused tail of IM with NOPs so no stale code survives
                w_im_we_nxt    = 1'b1;
                w_im_addr_nxt  = r_ptr[ADDR_W-1:0];
                w_im_wdata_nxt = NOP_BYTE;
                w_ptr_nxt      = w_ptr_inc;
                if (r_ptr == c_ptr_last) begin
                    w_state_nxt     = DONE;
                    w_load_done_nxt = 1'b1;
                end
            end
            DONE: begin
            end
            ERR: begin
            end
            default: begin
                w_state_nxt = HDR_HI;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= HDR_HI;
            r_n_hi       <= '0;
            r_n_words    <= '0;
            r_ptr        <= '0;
            r_csum       <= '0;
            r_word_count <= '0;
            r_im_we      <= 1'b0;
            r_im_addr    <= '0;
            r_im_wdata   <= '0;
            r_load_done  <= 1'b0;
            r_load_err   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_n_hi       <= w_n_hi_nxt;
            r_n_words    <= w_n_words_nxt;
            r_ptr        <= w_ptr_nxt;
            r_csum       <= w_csum_nxt;
            r_word_count <= w_word_count_nxt;
            r_im_we      <= w_im_we_nxt;
            r_im_addr    <= w_im_addr_nxt;
            r_im_wdata   <= w_im_wdata_nxt;
            r_load_done  <= w_load_done_nxt;
            r_load_err   <= w_load_err_nxt;
        end
    end

    assign im_we      = r_im_we;
    assign im_addr    = r_im_addr;
    assign im_wdata   = r_im_wdata;
    assign load_done  = r_load_done;
    assign load_err   = r_load_err;
    assign core_rst   = ~r_load_done;
    assign word_count = r_word_count;

endmodule
`default_nettype wire

// File: tb/tb_im_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_im_loader
//  Description : Scoreboard bench for im_loader: directed frames, expected IM
//                writes queued at issue time and matched by a write monitor.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_im_loader;

    localparam int IM_BYTES = 64;
    localparam int ADDR_W   = 6;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic [7:0]        in_data = 8'h00;
    logic              in_ready;
    logic              im_we;
    logic [ADDR_W-1:0] im_addr;
    logic [7:0]        im_wdata;
    logic              core_rst;
    logic              load_done;
    logic              load_err;
    logic [ADDR_W-2:0] word_count;

    im_loader #(
        .IM_BYTES (IM_BYTES),
        .ADDR_W   (ADDR_W)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .im_we      (im_we),
        .im_addr    (im_addr),
        .im_wdata   (im_wdata),
        .core_rst   (core_rst),
        .load_done  (load_done),
        .load_err   (load_err),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic              is_data;
        logic [ADDR_W-1:0] addr;
        logic [7:0]        data;
    } wr_t;

    wr_t        sb_q[$];
    wr_t        exp_wr;
    int         n_checks = 0;
    int         n_errors = 0;
    logic       prev_xfer = 1'b0;
    logic [7:0] img [0:IM_BYTES-1];

    always @(posedge clk) prev_xfer <= in_valid && in_ready && !rst;

    // Write monitor: every im_we pulse must match the oldest queued write
    always @(negedge clk) begin
        if (im_we) begin
            n_checks++;
            if (sb_q.size() == 0) begin
                n_errors++;
                $display("FAIL write_unexpected: got addr=%0d data=%02h, required no write",
                         im_addr, im_wdata);
            end else begin
                exp_wr = sb_q.pop_front();
                if (im_addr !== exp_wr.addr || im_wdata !== exp_wr.data) begin
                    n_errors++;
                    $display("FAIL write_value: got addr=%0d data=%02h, required addr=%0d data=%02h",
                             im_addr, im_wdata, exp_wr.addr, exp_wr.data);
                end else if (exp_wr.is_data && !prev_xfer) begin
                    n_errors++;
                    $display("FAIL write_latency: data write at addr=%0d without a transfer on the previous edge, required transfer",
                             im_addr);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Called at posedge+#1; returns at posedge+#1 after the accepting edge
    task automatic send_byte(input logic [7:0] b, input bit push, input int addr, input int gap);
        int t;
        while (gap > 0 && $urandom_range(99) < gap) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
        end
        if (push) sb_q.push_back({1'b1, ADDR_W'(addr), b});
        in_valid = 1'b1;
        in_data  = b;
        t = 0;
        while (!in_ready && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        if (!in_ready) begin
            n_checks++;
            n_errors++;
            $display("FAIL send_timeout: in_ready=0 for 20 cycles, required 1");
            in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input int nwords, input logic [7:0] csum, input bit good,
                              input int gap, input int stop_after);
        logic [15:0] n;
        n = 16'(nwords);
        send_byte(n[15:8], 1'b0, 0, gap);
        send_byte(n[7:0], 1'b0, 0, gap);
        for (int i = 0; i < 4 * nwords; i++) begin
            if (i == stop_after) return;
            send_byte(img[i], 1'b1, i, gap);
        end
        send_byte(csum, 1'b0, 0, gap);
        if (good)
            for (int a = 4 * nwords; a < IM_BYTES; a++)
                sb_q.push_back({1'b0, ADDR_W'(a), 8'h00});
        check("in_ready_after_csum", in_ready, 0);
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (sb_q.size() != 0 && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        check("scoreboard_drained", sb_q.size(), 0);
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (!load_done && !load_err && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic load_case1();
        img[0]  = 8'h8B; img[1]  = 8'h02; img[2]  = 8'h00; img[3]  = 8'h20;
        img[4]  = 8'hCB; img[5]  = 8'h03; img[6]  = 8'h00; img[7]  = 8'h41;
        img[8]  = 8'hF8; img[9]  = 8'h40; img[10] = 8'h00; img[11] = 8'h02;
    endtask

    task automatic check_case1_end(input string tag);
        wait_done();
        wait_drain();
        check({tag, "_load_done"},  load_done,  1);
        check({tag, "_core_rst"},   core_rst,   0);
        check({tag, "_load_err"},   load_err,   0);
        check({tag, "_word_count"}, word_count, 3);
    endtask

    logic [7:0] cs;

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_im_we",      im_we,      0);
        check("rst_im_addr",    im_addr,    0);
        check("rst_im_wdata",   im_wdata,   0);
        check("rst_core_rst",   core_rst,   1);
        check("rst_load_done",  load_done,  0);
        check("rst_load_err",   load_err,   0);
        check("rst_word_count", word_count, 0);
        check("rst_in_ready",   in_ready,   1);

        // Case 1: N=3, checksum 9A, tail filled with NOPs
        load_case1();
        send_frame(3, 8'h9A, 1'b1, 0, 999);
        check_case1_end("c1");

        // Case 2: full 64-byte image, no fill
        do_reset();
        cs = 8'h00;
        for (int i = 0; i < IM_BYTES; i++) begin
            img[i] = 8'(i * 37 + 5);
            cs = cs ^ img[i];
        end
        send_frame(16, cs, 1'b1, 0, 999);
        if (!load_done) begin
            @(posedge clk); #1;
        end
        check("c2_load_done",  load_done,  1);
        check("c2_core_rst",   core_rst,   0);
        check("c2_word_count", word_count, 16);
        wait_drain();

        // Case 3: N=17 overflows the IM
        do_reset();
        send_byte(8'h00, 1'b0, 0, 0);
        send_byte(8'h11, 1'b0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        check("c3_load_err",  load_err,  1);
        check("c3_core_rst",  core_rst,  1);
        check("c3_in_ready",  in_ready,  0);
        check("c3_load_done", load_done, 0);

        // Case 4: N=2, checksum 88 expected, 89 sent
        do_reset();
        img[0] = 8'h11; img[1] = 8'h22; img[2] = 8'h33; img[3] = 8'h44;
        img[4] = 8'h55; img[5] = 8'h66; img[6] = 8'h77; img[7] = 8'h88;
        send_frame(2, 8'h89, 1'b0, 0, 999);
        repeat (3) @(posedge clk);
        #1;
        wait_drain();
        check("c4_load_err",   load_err,   1);
        check("c4_load_done",  load_done,  0);
        check("c4_core_rst",   core_rst,   1);
        check("c4_word_count", word_count, 2);

        // Case 5: case 1 with random valid gaps
        do_reset();
        load_case1();
        send_frame(3, 8'h9A, 1'b1, 50, 999);
        check_case1_end("c5");

        // Case 6: abort after 5 data bytes, then reload
        do_reset();
        send_frame(3, 8'h9A, 1'b1, 0, 5);
        repeat (2) @(posedge clk);
        #1;
        wait_drain();
        check("c6_core_rst_mid", core_rst, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("c6_core_rst_in_rst", core_rst, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        check("c6_core_rst_after",   core_rst,   1);
        check("c6_word_count_after", word_count, 0);
        check("c6_in_ready_after",   in_ready,   1);
        send_frame(3, 8'h9A, 1'b1, 0, 999);
        check_case1_end("c6");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
